// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: issues word reads to a fixed-latency memory, buffers the
// returned words in a prefetch FIFO and hands them to decode over valid/ready.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q;
  logic [MEM_LAT-1:0] pipe_v;
  logic [31:0]       pipe_pc [MEM_LAT];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [LAT_W-1:0]  inflight;
  logic              issue, push, pop;

  // Requests still travelling through the memory pipe
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      inflight = inflight + LAT_W'(pipe_v[i]);
    end
  end

  // Only issue when every outstanding response is guaranteed a FIFO slot
  assign issue = (state_q == FETCH) && !redirect_valid &&
                 ((SUM_W'(fifo_cnt) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
  assign push  = pipe_v[MEM_LAT-1] && !redirect_valid;
  assign pop   = instr_valid && instr_ready && !redirect_valid;

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = (fifo_cnt != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign busy        = (inflight != '0) || (state_q == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en) state_d = FETCH;
      FETCH:   if (!fetch_en) state_d = IDLE;
      DRAIN:   if (inflight == '0) state_d = fetch_en ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
    // A redirect freezes IDLE/FETCH unless stale requests must be drained first
    if (redirect_valid) begin
      if (inflight != '0) begin
        state_d = DRAIN;
      end else if (state_q != DRAIN) begin
        state_d = state_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~32'h3;
    end else if (issue) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // In-flight valid pipe; clearing it drops every stale response at once
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= issue;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_pc[0] <= pc_q;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      pipe_pc[i] <= pipe_pc[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= pipe_pc[MEM_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic, checked by a
// scoreboard of the expected sequential instruction stream.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned MEM_LAT  = 1;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, instr_ready;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, instr, instr_pc;
  logic        imem_req, instr_valid, busy;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          outst   = 0;
  int          n_hs    = 0;
  logic [31:0] salt;
  logic [31:0] exp_next;
  exp_t        exp_q[$];
  exp_t        e;
  logic        hs, p_hold;
  logic [31:0] p_instr, p_pc;
  logic [31:0] mem_pipe [MEM_LAT];

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ salt;
  endfunction

  // Fixed-latency memory: word index (optionally salted) returned MEM_LAT cycles later
  always @(posedge clk) begin
    mem_pipe[0] <= imem_req ? word_at(imem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < int'(MEM_LAT); i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign imem_rdata = mem_pipe[MEM_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_t'{pc: exp_next, data: word_at(exp_next)});
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] target);
    exp_q.delete();
    exp_next = target & ~32'h3;
    topup();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'h0);
    chk({tag, "_addr"},  imem_addr, RESET_PC);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_ipc"},   instr_pc, 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    restart(target);
    cyc();
    redirect_valid = 1'b0;
  endtask

  // Monitor: delivered stream, handshake stability and buffering bound
  always @(negedge clk) begin
    if (rst) begin
      outst  = 0;
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        chk("hold_valid", 32'(instr_valid), 32'h1);
        chk("hold_instr", instr, p_instr);
        chk("hold_pc", instr_pc, p_pc);
      end
      hs = instr_valid && instr_ready && !redirect_valid;
      if (hs) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stream: got pc %h with no expected word", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", instr_pc, e.pc);
          chk("stream_instr", instr, e.data);
        end
      end
      if (redirect_valid) begin
        outst = 0;
      end else begin
        outst = outst + int'(imem_req) - int'(hs);
        n_tests++;
        if (outst > int'(DEPTH)) begin
          n_fail++;
          $display("FAIL occupancy: got %0d expected <= %0d", outst, DEPTH);
        end
      end
      p_hold  = instr_valid && !instr_ready && !redirect_valid;
      p_instr = instr;
      p_pc    = instr_pc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b0; salt = 32'h0;
    restart(RESET_PC);
    repeat (3) cyc();
    @(negedge clk);
    chk_reset("reset");

    // T1: first-word latency and in-order stream with mem[i]=i
    cyc();
    fetch_en = 1'b1; instr_ready = 1'b1; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(instr_valid), (k == 3) ? 32'h1 : 32'h0);
      if (k == 1) begin
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr", imem_addr, RESET_PC);
      end
      if (k == 3) chk("t1_first_instr", instr, 32'h0);
      if (k < 3) cyc();
    end
    repeat (8) cyc();

    // T2: backpressure fills exactly DEPTH entries, then resumes in order
    instr_ready = 1'b0;
    repeat (10) cyc();
    @(negedge clk);
    chk("t2_outstanding", 32'(outst), 32'(DEPTH));
    chk("t2_req", 32'(imem_req), 32'h0);
    chk("t2_valid", 32'(instr_valid), 32'h1);
    cyc();
    instr_ready = 1'b1;
    repeat (6) cyc();

    // T3: redirect to unaligned pc while buffer full
    instr_ready = 1'b0;
    repeat (8) cyc();
    do_redirect(32'h0000_0103);
    @(negedge clk);
    chk("t3_valid", 32'(instr_valid), 32'h0);
    cyc();
    instr_ready = 1'b1;
    repeat (8) cyc();

    // T4: redirect colliding with pop and an arriving response
    do_redirect(32'h0000_2000);
    @(negedge clk);
    chk("t4_valid", 32'(instr_valid), 32'h0);
    chk("t4_outstanding", 32'(outst), 32'h0);
    repeat (6) cyc();

    // T5: fetch_en dropped mid-stream, then resumed
    fetch_en = 1'b0;
    cyc();
    @(negedge clk);
    chk("t5_req", 32'(imem_req), 32'h0);
    chk("t5_busy_hi", 32'(busy), 32'h1);
    cyc();
    @(negedge clk);
    chk("t5_busy_lo", 32'(busy), 32'h0);
    repeat (4) cyc();
    fetch_en = 1'b1;
    repeat (8) cyc();

    // T6: reset while full, then wrap around via redirect
    instr_ready = 1'b0;
    repeat (8) cyc();
    rst  = 1'b1;
    salt = 32'h5A5A_1234;
    restart(RESET_PC);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_reset("t6");
    cyc();
    instr_ready = 1'b1;
    repeat (8) cyc();
    do_redirect(32'hFFFF_FFFC);
    repeat (6) cyc();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      fetch_en    = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        rst  = 1'b1;
        salt = $urandom;
        restart(RESET_PC);
      end else if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        restart(redirect_pc);
      end
      cyc();
      rst = 1'b0;
      redirect_valid = 1'b0;
    end
    fetch_en = 1'b0;
    instr_ready = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    chk("final_valid", 32'(instr_valid), 32'h0);
    chk("final_busy", 32'(busy), 32'h0);
    n_tests++;
    if (n_hs < 500) begin
      n_fail++;
      $display("FAIL progress: got %0d handshakes expected >= 500", n_hs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
